// File: rtl/shift_reg_sched_pkg.sv
// Shared constants and state encoding for the two-requester shift register scheduler.
package shift_sched_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_reg_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

endmodule

// File: rtl/shift_reg_sched.sv
// Shares one bidirectional shift register between requesters A and B, shifting
// for the requested count and returning the register contents with a done pulse.
module shift_reg_sched
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_dir,
  input  logic [CNT_W-1:0] a_cnt,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_dir,
  input  logic [CNT_W-1:0] b_cnt,
  input  logic [WIDTH-1:0] b_data,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_in,
  input  logic [WIDTH-1:0] sr_out,
  output logic             done_valid,
  output logic             done_id,
  output logic [WIDTH-1:0] done_data,
  output logic             busy
);

  state_e             state_q;
  logic               rr_q;
  logic               dir_q;
  logic               id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   data_q;

  logic [1:0]         gnt;
  logic               hs;
  logic               dir_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [WIDTH-1:0]   data_d;

  rr_arb2 u_arb (
    .req   ({b_valid, a_valid}),
    .ptr   (rr_q),
    .en    (state_q == IDLE),
    .grant (gnt)
  );

  // A grant is only ever issued to a valid requester, so any grant is a handshake.
  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign hs      = |gnt;

  always_comb begin
    dir_d  = gnt[1] ? b_dir  : a_dir;
    cnt_d  = gnt[1] ? b_cnt  : a_cnt;
    data_d = gnt[1] ? b_data : a_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= ID_A;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            id_q    <= gnt[1];
            state_q <= (cnt_d == '0) ? CAPTURE : SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= CAPTURE;
        end
        CAPTURE: begin
          rr_q    <= ~id_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // sr_out is the shift register's own flop output; done_data forwards it in CAPTURE.
  assign busy       = (state_q != IDLE);
  assign sr_sel     = (state_q == SHIFT) ? (dir_q ? SEL_RIGHT : SEL_LEFT) : SEL_HOLD;
  assign sr_in      = (state_q == SHIFT) ? data_q : '0;
  assign done_valid = (state_q == CAPTURE);
  assign done_id    = (state_q == CAPTURE) ? id_q : 1'b0;
  assign done_data  = (state_q == CAPTURE) ? sr_out : '0;

endmodule

// File: tb/tb_shift_reg_sched.sv
// Self-checking bench: behavioural shift register, scoreboard of expected
// completions, a vector table and hand-written multi-cycle sequences.
module tb_shift_reg_sched;
  import shift_sched_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, a_dir = 1'b0;
  logic [CW-1:0] a_cnt = '0;
  logic [W-1:0]  a_data = '0;
  logic          b_valid = 1'b0, b_dir = 1'b0;
  logic [CW-1:0] b_cnt = '0;
  logic [W-1:0]  b_data = '0;
  logic          a_ready, b_ready, done_valid, done_id, busy;
  logic [1:0]    sr_sel;
  logic [W-1:0]  sr_in, sr_out, done_data;

  logic [W-1:0]  sr_q = 4'b0110;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [1:0]    last_sel = SEL_HOLD;
  logic          last_done_id = 1'b0;

  typedef struct {
    bit          id;
    logic [1:0]  sel;
    logic [W-1:0] din;
    int          cnt;
    int          due;
    logic [W-1:0] data;
    int          shifts;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          id;
    bit          dir;
    logic [CW-1:0] cnt;
    logic [W-1:0]  data;
    logic [1:0]  exp_sel;
  } vec_t;

  shift_reg_sched #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dir(a_dir), .a_cnt(a_cnt), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dir(b_dir), .b_cnt(b_cnt), .b_data(b_data),
    .sr_sel(sr_sel), .sr_in(sr_in), .sr_out(sr_out),
    .done_valid(done_valid), .done_id(done_id), .done_data(done_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] shf(input logic [W-1:0] q, input logic [W-1:0] din, input logic dir);
    return dir ? {din[W-1], q[W-1:1]} : {q[W-2:0], din[0]};
  endfunction

  // Behavioural bidirectional shift register on the far side of sel/in/out.
  assign sr_out = sr_q;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sr_sel == SEL_LEFT)       sr_q <= shf(sr_q, sr_in, 1'b0);
    else if (sr_sel == SEL_RIGHT) sr_q <= shf(sr_q, sr_in, 1'b1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit id, input bit dir, input logic [CW-1:0] cnt, input logic [W-1:0] d);
    exp_t e;
    logic [W-1:0] v;
    v = sr_q;
    for (int i = 0; i < int'(cnt); i++) v = shf(v, d, dir);
    e.id = id; e.sel = dir ? SEL_RIGHT : SEL_LEFT; e.din = d;
    e.cnt = int'(cnt); e.due = cyc + int'(cnt) + 1; e.data = v; e.shifts = 0;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge, checks shift cycles and completions.
  initial begin
    exp_t e;
    bit post_done;
    post_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        post_done = 1'b0;
      end else begin
        if (post_done) begin
          chk("pulse_width", done_valid, 0);
          chk("busy_after_done", busy, 0);
          post_done = 1'b0;
        end
        if (a_valid && b_valid) chk("ready_onehot", a_ready & b_ready, 0);
        if (busy) chk("ready_while_busy", a_ready | b_ready, 0);
        if (sb.size() == 0) begin
          chk("stray_shift", sr_sel, SEL_HOLD);
          chk("stray_done", done_valid, 0);
        end else begin
          if (sr_sel != SEL_HOLD) begin
            chk("sr_sel", sr_sel, sb[0].sel);
            chk("sr_in", sr_in, sb[0].din);
            sb[0].shifts = sb[0].shifts + 1;
            last_sel = sr_sel;
          end
          if (done_valid) begin
            e = sb.pop_front();
            chk("done_id", done_id, e.id);
            chk("done_data", done_data, e.data);
            chk("done_cycle", cyc, e.due);
            chk("shift_cycles", e.shifts, e.cnt);
            last_done_id = done_id;
            post_done = 1'b1;
          end
        end
        if (a_valid && a_ready) push(1'b0, a_dir, a_cnt, a_data);
        if (b_valid && b_ready) push(1'b1, b_dir, b_cnt, b_data);
      end
    end
  end

  task automatic drive(input bit id, input bit dir, input logic [CW-1:0] cnt, input logic [W-1:0] d);
    if (id) begin b_valid = 1'b1; b_dir = dir; b_cnt = cnt; b_data = d; end
    else    begin a_valid = 1'b1; a_dir = dir; a_cnt = cnt; a_data = d; end
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send(input bit id, input bit dir, input logic [CW-1:0] cnt, input logic [W-1:0] d);
    int n;
    drive(id, dir, cnt, d);
    #1;
    if (!busy) chk("ready_comb", id ? b_ready : a_ready, 1);
    n = 0;
    while (!(id ? b_ready : a_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ready_timeout", int'(id ? b_ready : a_ready), 1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("done_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[6];
    int   order[4];
    int   ng, n, hs_a, hs_b;

    vecs[0] = '{id:1'b0, dir:1'b0, cnt:3'd2, data:4'b1001, exp_sel:SEL_LEFT};
    vecs[1] = '{id:1'b1, dir:1'b1, cnt:3'd4, data:4'b1010, exp_sel:SEL_RIGHT};
    vecs[2] = '{id:1'b0, dir:1'b0, cnt:3'd0, data:4'b0101, exp_sel:SEL_HOLD};
    vecs[3] = '{id:1'b0, dir:1'b1, cnt:3'd7, data:4'b1100, exp_sel:SEL_RIGHT};
    vecs[4] = '{id:1'b1, dir:1'b0, cnt:3'd5, data:4'b0011, exp_sel:SEL_LEFT};
    vecs[5] = '{id:1'b1, dir:1'b1, cnt:3'd1, data:4'b1111, exp_sel:SEL_RIGHT};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sr_sel", sr_sel, SEL_HOLD);
    chk("rst_sr_in", sr_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_done_data", done_data, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      last_sel = SEL_HOLD;
      send(vecs[i].id, vecs[i].dir, vecs[i].cnt, vecs[i].data);
      wait_done();
      chk("vec_sel", last_sel, vecs[i].exp_sel);
      chk("vec_done_id", last_done_id, vecs[i].id);
    end

    // Back-to-back: B raised while A is shifting must wait until the idle cycle after done.
    send(1'b0, 1'b0, 3'd3, 4'b0110);
    hs_a = cyc - 1;
    drive(1'b1, 1'b1, 3'd2, 4'b1000);
    n = 0;
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    hs_b = cyc;
    chk("b2b_b_grant_cycle", hs_b, hs_a + 5);
    @(posedge clk); #1 b_valid = 1'b0;
    wait_done();

    // Reset in the second shift cycle of a cnt=5 command.
    send(1'b0, 1'b0, 3'd5, 4'b1011);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", sr_sel, SEL_HOLD);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Both requesters held continuously: grants must alternate starting with A.
    drive(1'b0, 1'b0, 3'd1, 4'b0001);
    drive(1'b1, 1'b1, 3'd1, 4'b1000);
    #1;
    chk("ptr_a_after_rst_a", a_ready, 1);
    chk("ptr_a_after_rst_b", b_ready, 0);
    ng = 0; n = 0;
    while (ng < 4 && n < 60) begin
      @(negedge clk); n++;
      if (a_ready)      begin order[ng] = 0; ng++; end
      else if (b_ready) begin order[ng] = 1; ng++; end
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    chk("grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("grant_order", order[i], i % 2);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
